reg_file_sb: RTL and testbench
==============================

# reg_file_sb

Parametrised register file for the datapath, successor to the fixed 16 x 16-bit `regFile`. Adds an explicit write address, a dedicated special-result write port (mult/div high/remainder into R15), write-to-read bypass, an optional hard-wired zero register, and a per-register busy scoreboard. The scoreboard lets the control unit detect read-after-write hazards on multi-cycle operations. Sits between decode (read addresses, issue) and writeback (both write ports).

## Interface
- `WIDTH`, 16, data width in bits
- `NUM_REGS`, 16, register count (power of two, >= 4)
- `SP_REG`, 15, index written by the special port
- `ZERO_REG`, 0, 1 = register 0 always reads 0 and ignores writes
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-high; clears all registers and busy bits
- `readReg1`, `readReg2`  in  log2(NUM_REGS)  read addresses
- `op1`, `op2`  out  WIDTH  read data (bypassed)
- `RegWrite`  in  1  primary write enable
- `writeReg`  in  log2(NUM_REGS)  primary write address
- `wrData`  in  WIDTH  primary write data
- `SpWrite`  in  1  special write enable, target fixed at `SP_REG`
- `spData`  in  WIDTH  special write data
- `issueValid`  in  1  marks `issueReg` as having an in-flight producer
- `issueReg`  in  log2(NUM_REGS)  destination being issued
- `busy1`, `busy2`  out  1  operand N not yet available
- `hazard`  out  1  `busy1 | busy2`

## Operation
- Storage: NUM_REGS x WIDTH flops; all reset to 0.
- Commit: on the clock edge, `RegWrite` writes `wrData` to `writeReg`; `SpWrite` writes `spData` to `SP_REG`.
- Both ports targeting `SP_REG` in the same cycle: the primary port wins and the special data is dropped.
- `ZERO_REG=1`: writes to reg 0 are discarded, and reads of reg 0 return 0 with no bypass.
- Read: combinational.
  - If `RegWrite` is high and `writeReg == readRegN`, `opN = wrData`.
  - Else if `SpWrite` is high and `readRegN == SP_REG`, `opN = spData`.
  - Else `opN` is the stored value.
- Scoreboard: one busy bit per register.
  - Set on the edge where `issueValid` is high, at `issueReg`.
  - Cleared on the edge where either write port commits to that register.
  - Set and clear of the same register in one cycle: set wins, because a new producer is now in flight.
  - Issue to reg 0 with `ZERO_REG=1` is ignored.
- `busyN = busy[readRegN]`, forced to 0 when a bypass supplies `opN` in the same cycle. Also forced to 0 for reg 0 when `ZERO_REG=1`.
- Reset asserted mid-operation: registers and busy bits clear immediately; same-cycle writes and issues are lost.

## Timing
- Read latency: 0 cycles (combinational from address and bypass inputs).
- Write latency: visible through bypass in the same cycle, and from storage on the next cycle.
- Busy: visible the cycle after the issue edge; drops the cycle after the commit edge, or in the commit cycle itself via the bypass mask.
- Reset values: `op1`/`op2` = 0 for any address, `busy1`/`busy2`/`hazard` = 0.
- No combinational path from `issueValid` to any output.

## Structure
- Package `regfile_pkg`:
  - default constants `RF_WIDTH=16`, `RF_NUM_REGS=16`, `RF_SP_REG=15`
  - reg-index typedef sized by `$clog2(RF_NUM_REGS)`
- Sub-module `reg_scoreboard`:
  - busy vector with set/clear priority and two busy lookups
  - parametrised by `NUM_REGS` and `ZERO_REG`
- The top level holds storage, write arbitration and bypass muxes.

## Test plan
- Reset, then read regs 1 and 2 with no writes → `op1 = op2 = 0x0000`, `hazard = 0`.
- `RegWrite=1`, `writeReg=3`, `wrData=0x1010`, `readReg1=3` in the same cycle → `op1 = 0x1010` via bypass. Next cycle with `RegWrite=0` → `op1 = 0x1010` from storage.
- `RegWrite` to 15 with `0xAAAA` and `SpWrite` with `0x5555` in the same cycle → R15 reads `0xAAAA` afterwards.
- Issue to reg 4 → `busy1 = 1` while `readReg1=4`, held across 3 idle cycles. Write `0x00FF` to 4 → `busy1 = 0` and `op1 = 0x00FF` in the commit cycle; no busy next cycle.
- Issue to 5 and write 5 in the same cycle → busy remains set afterwards.
- `ZERO_REG=1` build: write `0xBEEF` to reg 0 → reads 0; issue to 0 → never busy.
- Reset asserted asynchronously mid-cycle with regs written and busy set → all outputs 0 before the next edge.

Source files
------------

// File: rtl/regfile_pkg.sv
// ----------------------------------------------------------------------------
// regfile_pkg
// Shared constants and types for the datapath register file (reg_file_sb)
// and its busy scoreboard (reg_scoreboard).
//
// Contents:
//   RF_WIDTH     default data width of one register
//   RF_NUM_REGS  default number of architectural registers
//   RF_SP_REG    default register written by the special-result port
//   reg_idx_t    register index type for the default configuration
//   rf_idx_w     index width for an arbitrary register count (minimum 1 bit)
// ----------------------------------------------------------------------------
package regfile_pkg;

   localparam int RF_WIDTH    = 16;
   localparam int RF_NUM_REGS = 16;
   localparam int RF_SP_REG   = 15;

   typedef logic [$clog2(RF_NUM_REGS)-1:0] reg_idx_t;

   // Index width for a register count; never collapses to zero bits.
   function automatic int rf_idx_w(input int num_regs);
      return (num_regs > 1) ? $clog2(num_regs) : 1;
   endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// ----------------------------------------------------------------------------
// reg_scoreboard
// One busy bit per register. A bit is set when a multi-cycle producer is
// issued to that register and cleared when a write port commits to it.
// If both happen on the same edge the set wins: the commit belongs to the
// older producer, while the issue announces a newer one still in flight.
//
// Ports:
//   clk          clock, state updates on rising edge
//   reset        asynchronous active-high, clears every busy bit
//   issue_valid  an in-flight producer is being issued this cycle
//   issue_reg    destination register of that producer
//   commit       one bit per register committed by a write port this edge
//   rd_reg1/2    register indices being read
//   bypass1/2    the read port is being served by a same-cycle write
//   busy1/2      the operand on that read port is not yet available
// ----------------------------------------------------------------------------
module reg_scoreboard
   import regfile_pkg::*;
#(
   parameter int NUM_REGS = RF_NUM_REGS,
   parameter bit ZERO_REG = 1'b0
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 issue_valid,
   input  logic [rf_idx_w(NUM_REGS)-1:0]        issue_reg,
   input  logic [NUM_REGS-1:0]                  commit,
   input  logic [rf_idx_w(NUM_REGS)-1:0]        rd_reg1,
   input  logic [rf_idx_w(NUM_REGS)-1:0]        rd_reg2,
   input  logic                                 bypass1,
   input  logic                                 bypass2,
   output logic                                 busy1,
   output logic                                 busy2
);

   localparam int AW = rf_idx_w(NUM_REGS);

   logic [NUM_REGS-1:0] busy;
   logic [NUM_REGS-1:0] busy_next;
   logic                issue_ok;

   // Register 0 is hard-wired in the ZERO_REG build and can never be pending.
   function automatic logic is_zero(input logic [AW-1:0] idx);
      return ZERO_REG && (idx == '0);
   endfunction

   always_comb begin
      issue_ok  = issue_valid && !is_zero(issue_reg);
      busy_next = busy & ~commit;
      // Applied after the clear so a same-edge issue keeps the bit set.
      if (issue_ok) begin
         busy_next[issue_reg] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy <= '0;
      end else begin
         busy <= busy_next;
      end
   end

   // A bypassed operand is already available, so its busy bit is masked.
   always_comb begin
      busy1 = busy[rd_reg1] && !bypass1 && !is_zero(rd_reg1);
      busy2 = busy[rd_reg2] && !bypass2 && !is_zero(rd_reg2);
   end

endmodule

// File: rtl/reg_file_sb.sv
// ----------------------------------------------------------------------------
// reg_file_sb
// Parametrised two-read, two-write register file with write-to-read bypass,
// an optional hard-wired zero register and a per-register busy scoreboard
// used by control to detect read-after-write hazards on multi-cycle ops.
//
// Parameters:
//   WIDTH     data width
//   NUM_REGS  register count (power of two, >= 4)
//   SP_REG    register written by the special-result port
//   ZERO_REG  1 = register 0 reads 0 and ignores writes and issues
//
// Ports:
//   clk                 clock, state updates on rising edge
//   reset               asynchronous active-high, clears registers and busy
//   readReg1/readReg2   read addresses
//   op1/op2             read data, combinational with bypass
//   RegWrite/writeReg/wrData   primary write port
//   SpWrite/spData      special write port, target fixed at SP_REG
//   issueValid/issueReg marks issueReg as having an in-flight producer
//   busy1/busy2         operand N not yet available
//   hazard              busy1 | busy2
// ----------------------------------------------------------------------------
module reg_file_sb
   import regfile_pkg::*;
#(
   parameter int WIDTH    = RF_WIDTH,
   parameter int NUM_REGS = RF_NUM_REGS,
   parameter int SP_REG   = RF_SP_REG,
   parameter bit ZERO_REG = 1'b0
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [rf_idx_w(NUM_REGS)-1:0]        readReg1,
   input  logic [rf_idx_w(NUM_REGS)-1:0]        readReg2,
   output logic [WIDTH-1:0]                     op1,
   output logic [WIDTH-1:0]                     op2,
   input  logic                                 RegWrite,
   input  logic [rf_idx_w(NUM_REGS)-1:0]        writeReg,
   input  logic [WIDTH-1:0]                     wrData,
   input  logic                                 SpWrite,
   input  logic [WIDTH-1:0]                     spData,
   input  logic                                 issueValid,
   input  logic [rf_idx_w(NUM_REGS)-1:0]        issueReg,
   output logic                                 busy1,
   output logic                                 busy2,
   output logic                                 hazard
);

   localparam int            AW     = rf_idx_w(NUM_REGS);
   localparam logic [AW-1:0] SP_IDX = AW'(SP_REG);

   logic [WIDTH-1:0]    regs [NUM_REGS];
   logic                pri_we;
   logic                sp_we;
   logic [NUM_REGS-1:0] commit_vec;
   logic                byp1;
   logic                byp2;

   function automatic logic is_zero(input logic [AW-1:0] idx);
      return ZERO_REG && (idx == '0);
   endfunction

   // Write arbitration: the primary port owns SP_REG when both target it,
   // so the special data is simply dropped rather than merged.
   always_comb begin
      pri_we = RegWrite && !is_zero(writeReg);
      sp_we  = SpWrite && !(RegWrite && (writeReg == SP_IDX)) && !is_zero(SP_IDX);
   end

   always_comb begin
      commit_vec = '0;
      if (pri_we) begin
         commit_vec[writeReg] = 1'b1;
      end
      if (sp_we) begin
         commit_vec[SP_IDX] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else begin
         if (pri_we) begin
            regs[writeReg] <= wrData;
         end
         if (sp_we) begin
            regs[SP_IDX] <= spData;
         end
      end
   end

   // Read muxes: zero register first (never bypassed), then primary write,
   // then special write, then storage. The bypass priority mirrors the
   // write arbitration so a read sees exactly what will be stored.
   always_comb begin
      byp1 = 1'b0;
      op1  = regs[readReg1];
      if (is_zero(readReg1)) begin
         op1 = '0;
      end else if (RegWrite && (writeReg == readReg1)) begin
         op1  = wrData;
         byp1 = 1'b1;
      end else if (SpWrite && (readReg1 == SP_IDX)) begin
         op1  = spData;
         byp1 = 1'b1;
      end
   end

   always_comb begin
      byp2 = 1'b0;
      op2  = regs[readReg2];
      if (is_zero(readReg2)) begin
         op2 = '0;
      end else if (RegWrite && (writeReg == readReg2)) begin
         op2  = wrData;
         byp2 = 1'b1;
      end else if (SpWrite && (readReg2 == SP_IDX)) begin
         op2  = spData;
         byp2 = 1'b1;
      end
   end

   reg_scoreboard #(
      .NUM_REGS (NUM_REGS),
      .ZERO_REG (ZERO_REG)
   ) u_scoreboard (
      .clk         (clk),
      .reset       (reset),
      .issue_valid (issueValid),
      .issue_reg   (issueReg),
      .commit      (commit_vec),
      .rd_reg1     (readReg1),
      .rd_reg2     (readReg2),
      .bypass1     (byp1),
      .bypass2     (byp2),
      .busy1       (busy1),
      .busy2       (busy2)
   );

   assign hazard = busy1 | busy2;

endmodule

// File: tb/tb_reg_file_sb.sv
// ----------------------------------------------------------------------------
// tb_reg_file_sb
// Drives a default build (dut_n) and a ZERO_REG=1 build (dut_z) with the
// same stimulus and compares both against a behavioural model of the
// register contents and pending-producer set.
// ----------------------------------------------------------------------------
module tb_reg_file_sb;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  r1 = '0, r2 = '0, wreg = '0, ireg = '0;
   logic        rw = 1'b0, sw = 1'b0, iv = 1'b0;
   logic [15:0] wdata = '0, sdata = '0;

   logic [15:0] op1_w [2];
   logic [15:0] op2_w [2];
   logic        busy1_w [2];
   logic        busy2_w [2];
   logic        hazard_w [2];

   // Model state: index 0 = default build, index 1 = zero-register build.
   logic [15:0] m_reg  [2][16];
   bit          m_busy [2][16];

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   reg_file_sb #(.ZERO_REG(1'b0)) dut_n (
      .clk(clk), .reset(reset),
      .readReg1(r1), .readReg2(r2), .op1(op1_w[0]), .op2(op2_w[0]),
      .RegWrite(rw), .writeReg(wreg), .wrData(wdata),
      .SpWrite(sw), .spData(sdata),
      .issueValid(iv), .issueReg(ireg),
      .busy1(busy1_w[0]), .busy2(busy2_w[0]), .hazard(hazard_w[0])
   );

   reg_file_sb #(.ZERO_REG(1'b1)) dut_z (
      .clk(clk), .reset(reset),
      .readReg1(r1), .readReg2(r2), .op1(op1_w[1]), .op2(op2_w[1]),
      .RegWrite(rw), .writeReg(wreg), .wrData(wdata),
      .SpWrite(sw), .spData(sdata),
      .issueValid(iv), .issueReg(ireg),
      .busy1(busy1_w[1]), .busy2(busy2_w[1]), .hazard(hazard_w[1])
   );

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, got, exp);
   endtask

   // Value a reader sees this cycle: the register as it will be after the
   // current edge, where a primary write to R15 supersedes a special write.
   function automatic logic [15:0] exp_op(input int z, input int rr);
      if (z == 1 && rr == 0) return 16'h0000;
      if (rw && int'(wreg) == rr) return wdata;
      if (sw && rr == 15) return sdata;
      return m_reg[z][rr];
   endfunction

   function automatic logic exp_busy(input int z, input int rr);
      if (z == 1 && rr == 0) return 1'b0;
      if (rw && int'(wreg) == rr) return 1'b0;
      if (sw && rr == 15) return 1'b0;
      return m_busy[z][rr];
   endfunction

   task automatic check_all();
      logic b1, b2;
      for (int z = 0; z < 2; z++) begin
         b1 = exp_busy(z, int'(r1));
         b2 = exp_busy(z, int'(r2));
         chk($sformatf("op1[b%0d r%0d]", z, r1), op1_w[z], exp_op(z, int'(r1)));
         chk($sformatf("op2[b%0d r%0d]", z, r2), op2_w[z], exp_op(z, int'(r2)));
         chk($sformatf("busy1[b%0d r%0d]", z, r1), 16'(busy1_w[z]), 16'(b1));
         chk($sformatf("busy2[b%0d r%0d]", z, r2), 16'(busy2_w[z]), 16'(b2));
         chk($sformatf("hazard[b%0d]", z), 16'(hazard_w[z]), 16'(b1 | b2));
      end
   endtask

   task automatic drive(input logic a_rw, input logic [3:0] a_wreg, input logic [15:0] a_wd,
                        input logic a_sw, input logic [15:0] a_sd,
                        input logic a_iv, input logic [3:0] a_ireg,
                        input logic [3:0] a_r1, input logic [3:0] a_r2);
      @(negedge clk);
      rw = a_rw; wreg = a_wreg; wdata = a_wd;
      sw = a_sw; sdata = a_sd;
      iv = a_iv; ireg = a_ireg;
      r1 = a_r1; r2 = a_r2;
      #1;
      check_all();
   endtask

   task automatic idle(input logic [3:0] a_r1, input logic [3:0] a_r2);
      drive(1'b0, 4'd0, 16'h0, 1'b0, 16'h0, 1'b0, 4'd0, a_r1, a_r2);
   endtask

   // Advance the model across one rising edge using the held inputs.
   task automatic tick();
      @(posedge clk);
      for (int z = 0; z < 2; z++) begin
         if (sw) m_reg[z][15] = sdata;
         if (rw && !(z == 1 && wreg == 4'd0)) m_reg[z][wreg] = wdata;
         if (sw) m_busy[z][15] = 1'b0;
         if (rw) m_busy[z][wreg] = 1'b0;
         if (iv && !(z == 1 && ireg == 4'd0)) m_busy[z][ireg] = 1'b1;
      end
   endtask

   task automatic model_clear();
      for (int z = 0; z < 2; z++)
         for (int i = 0; i < 16; i++) begin
            m_reg[z][i]  = 16'h0;
            m_busy[z][i] = 1'b0;
         end
   endtask

   task automatic rand_step();
      logic        a_rw, a_sw, a_iv;
      logic [3:0]  a_wreg, a_ireg, a_r1, a_r2;
      a_rw   = ($urandom_range(0, 99) < 40);
      a_sw   = ($urandom_range(0, 99) < 20);
      a_iv   = ($urandom_range(0, 99) < 30);
      a_wreg = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
      a_ireg = 4'($urandom_range(0, 15));
      a_r1   = ($urandom_range(0, 3) == 0) ? a_wreg : 4'($urandom_range(0, 15));
      a_r2   = ($urandom_range(0, 4) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
      drive(a_rw, a_wreg, 16'($urandom), a_sw, 16'($urandom), a_iv, a_ireg, a_r1, a_r2);
      tick();
   endtask

   initial begin
      model_clear();
      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      r1 = 4'd1; r2 = 4'd2;
      #1;
      check_all();
      @(negedge clk);
      reset = 1'b0;

      // Empty file reads zero, no hazard
      idle(4'd1, 4'd2);
      chk("reset_op1", op1_w[0], 16'h0000);
      chk("reset_op2", op2_w[0], 16'h0000);
      chk("reset_hazard", 16'(hazard_w[0]), 16'h0);
      tick();

      // Same-cycle bypass, then storage
      drive(1'b1, 4'd3, 16'h1010, 1'b0, 16'h0, 1'b0, 4'd0, 4'd3, 4'd2);
      chk("bypass_r3", op1_w[0], 16'h1010);
      tick();
      idle(4'd3, 4'd2);
      chk("stored_r3", op1_w[0], 16'h1010);
      tick();

      // Primary beats special on R15
      drive(1'b1, 4'd15, 16'hAAAA, 1'b1, 16'h5555, 1'b0, 4'd0, 4'd15, 4'd15);
      chk("r15_conflict_byp", op1_w[0], 16'hAAAA);
      tick();
      idle(4'd15, 4'd3);
      chk("r15_conflict_store", op1_w[0], 16'hAAAA);
      tick();

      // Special port alone into R15
      drive(1'b0, 4'd0, 16'h0, 1'b1, 16'h5A5A, 1'b0, 4'd0, 4'd15, 4'd1);
      chk("sp_byp", op1_w[0], 16'h5A5A);
      tick();
      idle(4'd1, 4'd15);
      chk("sp_store", op2_w[0], 16'h5A5A);
      tick();

      // Issue to 4, busy for several cycles, cleared by commit
      drive(1'b0, 4'd0, 16'h0, 1'b0, 16'h0, 1'b1, 4'd4, 4'd4, 4'd1);
      chk("issue_cycle_busy", 16'(busy1_w[0]), 16'h0);
      tick();
      for (int i = 0; i < 3; i++) begin
         idle(4'd4, 4'd1);
         chk("busy4_held", 16'(busy1_w[0]), 16'h1);
         chk("hazard4_held", 16'(hazard_w[0]), 16'h1);
         tick();
      end
      drive(1'b1, 4'd4, 16'h00FF, 1'b0, 16'h0, 1'b0, 4'd0, 4'd4, 4'd1);
      chk("commit_busy4", 16'(busy1_w[0]), 16'h0);
      chk("commit_op4", op1_w[0], 16'h00FF);
      tick();
      idle(4'd4, 4'd1);
      chk("after_commit_busy4", 16'(busy1_w[0]), 16'h0);
      tick();

      // Issue and commit to 5 on the same edge: set wins
      drive(1'b1, 4'd5, 16'h0505, 1'b0, 16'h0, 1'b1, 4'd5, 4'd5, 4'd0);
      tick();
      idle(4'd1, 4'd5);
      chk("set_wins_busy5", 16'(busy2_w[0]), 16'h1);
      tick();
      drive(1'b1, 4'd5, 16'h0506, 1'b0, 16'h0, 1'b0, 4'd0, 4'd5, 4'd0);
      tick();

      // Zero register behaviour
      drive(1'b1, 4'd0, 16'hBEEF, 1'b0, 16'h0, 1'b0, 4'd0, 4'd0, 4'd0);
      chk("zero_byp_z", op1_w[1], 16'h0000);
      chk("zero_byp_n", op1_w[0], 16'hBEEF);
      tick();
      idle(4'd0, 4'd3);
      chk("zero_store_z", op1_w[1], 16'h0000);
      chk("zero_store_n", op1_w[0], 16'hBEEF);
      tick();
      drive(1'b0, 4'd0, 16'h0, 1'b0, 16'h0, 1'b1, 4'd0, 4'd0, 4'd0);
      tick();
      idle(4'd0, 4'd0);
      chk("zero_busy_z", 16'(busy1_w[1]), 16'h0);
      chk("zero_busy_n", 16'(busy1_w[0]), 16'h1);
      tick();
      drive(1'b1, 4'd0, 16'h0000, 1'b0, 16'h0, 1'b0, 4'd0, 4'd0, 4'd0);
      tick();

      // Randomised traffic
      for (int i = 0; i < 400; i++) rand_step();

      // Asynchronous reset in the middle of a cycle
      drive(1'b1, 4'd7, 16'h1234, 1'b0, 16'h0, 1'b1, 4'd8, 4'd7, 4'd8);
      tick();
      idle(4'd7, 4'd8);
      chk("pre_reset_op7", op1_w[0], 16'h1234);
      chk("pre_reset_busy8", 16'(busy2_w[0]), 16'h1);
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      model_clear();
      for (int z = 0; z < 2; z++) begin
         chk($sformatf("rst_op1[b%0d]", z), op1_w[z], 16'h0);
         chk($sformatf("rst_op2[b%0d]", z), op2_w[z], 16'h0);
         chk($sformatf("rst_busy2[b%0d]", z), 16'(busy2_w[z]), 16'h0);
         chk($sformatf("rst_hazard[b%0d]", z), 16'(hazard_w[z]), 16'h0);
      end
      r1 = 4'd15; r2 = 4'd3;
      #1;
      check_all();
      @(negedge clk);
      #1;
      reset = 1'b0;
      for (int i = 0; i < 60; i++) rand_step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
